// File: rtl/array_4_feeder.sv
// Edge feeder for the 4x4 rate-coded uGEMM array: weight preload, skewed ifm streaming, ofm drain.
// Optional FEEDER_PERF_CNT_EN adds o_stall_cnt, a saturating count of ICOMP bubble cycles.
module array_4_feeder #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [CWIDTH-1:0]              i_mac_cyc,
  input  logic [CWIDTH-1:0]              i_num_vec,
  input  logic [WIDTH-1:0][IWIDTH-1:0]   i_wght_in,
  input  logic                           i_wght_valid,
  output logic                           o_wght_ready,
  input  logic [HEIGHT-1:0][IWIDTH-1:0]  i_ifm_in,
  input  logic                           i_ifm_valid,
  output logic                           o_ifm_ready,
  output logic [HEIGHT-1:0]              o_en_i,
  output logic [HEIGHT-1:0]              o_clr_i,
  output logic [HEIGHT-1:0]              o_mac_done,
  output logic [HEIGHT-1:0][IWIDTH-1:0]  o_ifm,
  output logic [WIDTH-1:0]               o_en_w,
  output logic [WIDTH-1:0]               o_clr_w,
  output logic [WIDTH-1:0][IWIDTH-1:0]   o_wght,
  output logic [WIDTH-1:0]               o_en_o,
  output logic [WIDTH-1:0]               o_clr_o,
  output logic                           o_busy,
  output logic                           o_done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [15:0]                    o_stall_cnt
`endif
);

  localparam int D0   = HEIGHT + WIDTH - 1;
  localparam int DEND = D0 + WIDTH + HEIGHT;
  localparam int CNTW = $clog2(DEND + 1);
  localparam logic [CNTW-1:0] BEAT_LAST  = CNTW'(HEIGHT - 1);
  localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(DEND);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WCLR,
    S_WLOAD,
    S_ICOMP,
    S_DRAIN
  } state_t;

  state_t                          r_state;
  logic                            r_busy;
  logic                            r_done;
  logic [CWIDTH-1:0]               r_mac;
  logic [CWIDTH-1:0]               r_num;
  logic [CWIDTH-1:0]               r_p;
  logic [CWIDTH-1:0]               r_v;
  logic [CNTW-1:0]                 r_cnt;
  logic [WIDTH-1:0]                r_en_w;
  logic [WIDTH-1:0]                r_clr_w;
  logic [WIDTH-1:0][IWIDTH-1:0]    r_wght;
  logic [WIDTH-1:0]                r_en_o;
  logic [WIDTH-1:0]                r_clr_o;
  logic                            r_pEn;
  logic                            r_pClr;
  logic                            r_pDone;
  logic [HEIGHT-1:0][IWIDTH-1:0]   r_pIfm;

  logic                            w_ifmOpen;
  logic                            w_ifmAcc;
  logic                            w_wghtAcc;
  logic [CWIDTH-1:0]               w_macLast;
  logic [WIDTH-1:0]                w_enONext;
  logic [WIDTH-1:0]                w_clrONext;
  logic                            w_doneNext;
  logic [IWIDTH+2:0]               w_row [HEIGHT];

  assign o_wght_ready = (r_state == S_WLOAD);
  assign w_wghtAcc    = o_wght_ready && i_wght_valid;
  assign w_ifmOpen    = (r_state == S_ICOMP) && (r_p == '0) && (r_v < r_num);
  assign o_ifm_ready  = w_ifmOpen;
  assign w_ifmAcc     = w_ifmOpen && i_ifm_valid;
  assign w_macLast    = r_mac - CWIDTH'(1);

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_en_w  = r_en_w;
  assign o_clr_w = r_clr_w;
  assign o_wght  = r_wght;
  assign o_en_o  = r_en_o;
  assign o_clr_o = r_clr_o;

  // Drain windows are decoded for the next drain count so the column outputs stay registered.
  always_comb begin
    int dn;
    dn         = int'(r_cnt) + 1;
    w_enONext  = '0;
    w_clrONext = '0;
    for (int w = 0; w < WIDTH; w++) begin
      w_enONext[w]  = (dn >= D0 + w) && (dn <= D0 + w + HEIGHT - 1);
      w_clrONext[w] = (dn == D0 + w + HEIGHT);
    end
    w_doneNext = (dn == DEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mac   <= '0;
      r_num   <= '0;
      r_p     <= '0;
      r_v     <= '0;
      r_cnt   <= '0;
      r_en_w  <= '0;
      r_clr_w <= '0;
      r_wght  <= '0;
      r_en_o  <= '0;
      r_clr_o <= '0;
      r_pEn   <= 1'b0;
      r_pClr  <= 1'b0;
      r_pDone <= 1'b0;
      r_pIfm  <= '0;
    end else begin
      r_en_w  <= '0;
      r_clr_w <= '0;
      r_en_o  <= '0;
      r_clr_o <= '0;
      r_done  <= 1'b0;
      r_pEn   <= 1'b0;
      r_pClr  <= 1'b0;
      r_pDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_WCLR;
            r_busy  <= 1'b1;
            r_clr_w <= '1;
            r_mac   <= (i_mac_cyc == '0) ? CWIDTH'(1) : i_mac_cyc;
            r_num   <= (i_num_vec == '0) ? CWIDTH'(1) : i_num_vec;
            r_p     <= '0;
            r_v     <= '0;
            r_cnt   <= '0;
          end
        end
        S_WCLR: begin
          r_state <= S_WLOAD;
          r_cnt   <= '0;
        end
        S_WLOAD: begin
          if (w_wghtAcc) begin
            r_en_w <= '1;
            r_wght <= i_wght_in;
            if (r_cnt == BEAT_LAST) begin
              r_state <= S_ICOMP;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_ICOMP: begin
          if (r_p != '0) begin
            r_pEn   <= 1'b1;
            r_pDone <= (r_p == w_macLast);
            r_p     <= (r_p == w_macLast) ? '0 : r_p + 1'b1;
          end else if (w_ifmAcc) begin
            r_pEn   <= 1'b1;
            r_pClr  <= 1'b1;
            r_pDone <= (r_mac == CWIDTH'(1));
            r_pIfm  <= i_ifm_in;
            r_v     <= r_v + 1'b1;
            r_p     <= (r_mac == CWIDTH'(1)) ? '0 : CWIDTH'(1);
          end else if (r_pDone && (r_v == r_num)) begin
            // Row 0 is showing the last mac_done; the drain count starts on the next cycle.
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          r_cnt   <= r_cnt + 1'b1;
          r_en_o  <= w_enONext;
          r_clr_o <= w_clrONext;
          r_done  <= w_doneNext;
          if (r_cnt == DRAIN_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_en_o  <= '0;
            r_clr_o <= '0;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Row h carries its controls and its own ifm lane through an h-deep delay line.
  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    if (h == 0) begin : g_direct
      assign w_row[h] = {r_pEn, r_pClr, r_pDone, r_pIfm[0]};
    end else begin : g_delay
      logic [IWIDTH+2:0] r_line [h];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < h; k++) r_line[k] <= '0;
        end else begin
          r_line[0] <= {r_pEn, r_pClr, r_pDone, r_pIfm[h]};
          for (int k = 1; k < h; k++) r_line[k] <= r_line[k-1];
        end
      end
      assign w_row[h] = r_line[h-1];
    end
  end

  always_comb begin
    o_en_i     = '0;
    o_clr_i    = '0;
    o_mac_done = '0;
    o_ifm      = '0;
    for (int h = 0; h < HEIGHT; h++) begin
      o_en_i[h]     = w_row[h][IWIDTH+2];
      o_clr_i[h]    = w_row[h][IWIDTH+1];
      o_mac_done[h] = w_row[h][IWIDTH];
      o_ifm[h]      = w_row[h][IWIDTH-1:0];
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] r_stall;
  assign o_stall_cnt = r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_stall <= '0;
    end else if (w_ifmOpen && !i_ifm_valid && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_array_4_feeder.sv
// Randomized bench for array_4_feeder: a cycle-indexed event model predicts every edge output.
// Build with FEEDER_PERF_CNT_EN to also track the stall counter.
module tb_array_4_feeder;

  localparam int H    = 4;
  localparam int W    = 4;
  localparam int IW   = 16;
  localparam int CW   = 8;
  localparam int D0   = H + W - 1;
  localparam int DEND = D0 + W + H;
  localparam int MAXV = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start;
  logic [CW-1:0]          macCyc;
  logic [CW-1:0]          numVec;
  logic [W-1:0][IW-1:0]   wghtIn;
  logic                   wghtValid;
  logic                   wghtReady;
  logic [H-1:0][IW-1:0]   ifmIn;
  logic                   ifmValid;
  logic                   ifmReady;
  logic [H-1:0]           enI;
  logic [H-1:0]           clrI;
  logic [H-1:0]           macDone;
  logic [H-1:0][IW-1:0]   ifmOut;
  logic [W-1:0]           enW;
  logic [W-1:0]           clrW;
  logic [W-1:0][IW-1:0]   wghtOut;
  logic [W-1:0]           enO;
  logic [W-1:0]           clrO;
  logic                   busy;
  logic                   done;
`ifdef FEEDER_PERF_CNT_EN
  logic [15:0]            stallCnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  array_4_feeder #(.HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .CWIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_mac_cyc(macCyc), .i_num_vec(numVec),
    .i_wght_in(wghtIn), .i_wght_valid(wghtValid), .o_wght_ready(wghtReady),
    .i_ifm_in(ifmIn), .i_ifm_valid(ifmValid), .o_ifm_ready(ifmReady),
    .o_en_i(enI), .o_clr_i(clrI), .o_mac_done(macDone), .o_ifm(ifmOut),
    .o_en_w(enW), .o_clr_w(clrW), .o_wght(wghtOut),
    .o_en_o(enO), .o_clr_o(clrO), .o_busy(busy), .o_done(done)
`ifdef FEEDER_PERF_CNT_EN
    , .o_stall_cnt(stallCnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [CW-1:0] mac, input logic [CW-1:0] num,
                               input logic wv, input logic [W-1:0][IW-1:0] wd,
                               input logic iv, input logic [H-1:0][IW-1:0] id);
    start     = st;
    macCyc    = mac;
    numVec    = num;
    wghtValid = wv;
    wghtIn    = wd;
    ifmValid  = iv;
    ifmIn     = id;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, ".enI"}, 64'(enI), 64'd0);
    checkOutput({tag, ".clrI"}, 64'(clrI), 64'd0);
    checkOutput({tag, ".macDone"}, 64'(macDone), 64'd0);
    checkOutput({tag, ".ifm"}, 64'(ifmOut), 64'd0);
    checkOutput({tag, ".enW"}, 64'(enW), 64'd0);
    checkOutput({tag, ".clrW"}, 64'(clrW), 64'd0);
    checkOutput({tag, ".wght"}, 64'(wghtOut), 64'd0);
    checkOutput({tag, ".enO"}, 64'(enO), 64'd0);
    checkOutput({tag, ".clrO"}, 64'(clrO), 64'd0);
    checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
    checkOutput({tag, ".done"}, 64'(done), 64'd0);
    checkOutput({tag, ".wReady"}, 64'(wghtReady), 64'd0);
    checkOutput({tag, ".iReady"}, 64'(ifmReady), 64'd0);
`ifdef FEEDER_PERF_CNT_EN
    checkOutput({tag, ".stall"}, 64'(stallCnt), 64'd0);
`endif
  endtask

  task automatic midReset();
    #2 rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    #1 checkZeroOutputs("midReset");
    @(negedge clk);
    checkZeroOutputs("heldReset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postReset.busy", 64'(busy), 64'd0);
    checkOutput("postReset.wReady", 64'(wghtReady), 64'd0);
    checkOutput("postReset.iReady", 64'(ifmReady), 64'd0);
  endtask

  // Cycle c=0 drives start; model predicts each cycle's outputs from the handshakes seen so far.
  task automatic runTile(input int macIn, input int numIn, input int ifmPct, input int fixedGap,
                         input int wPct, input int rstOfs);
    int m, n, c, beats, s, boundary, nAcc, stalls, q, doneCyc, gapRun, d, t;
    int beatCyc [H];
    int accCyc [MAXV];
    logic [W-1:0][IW-1:0] beatData [H];
    logic [H-1:0][IW-1:0] vecData [MAXV];
    logic expBusy, expWReady, expIReady, expDone, finished;
    logic [W-1:0] expClrW, expEnW, expEnO, expClrO;
    logic [W-1:0][IW-1:0] expWght;
    logic [H-1:0] expEnI, expClrI, expDoneI;
    logic [H-1:0][IW-1:0] expIfm;
    logic st, wv, iv;
    logic [CW-1:0] mac, num;
    logic [W-1:0][IW-1:0] wd;
    logic [H-1:0][IW-1:0] id;

    m = (macIn == 0) ? 1 : macIn;
    n = (numIn == 0) ? 1 : numIn;
    for (int j = 0; j < H; j++) beatData[j] = rand64();
    for (int k = 0; k < MAXV; k++) vecData[k] = rand64();
    beats = 0; s = -1; boundary = -1; nAcc = 0; stalls = 0;
    q = -1; doneCyc = -1; gapRun = 0; c = 0; finished = 1'b0;

    while (!finished) begin
      expBusy   = (c >= 1) && ((q < 0) || (c <= doneCyc));
      expClrW   = (c == 1) ? '1 : '0;
      expEnW    = '0;
      expWght   = '0;
      for (int j = 0; j < beats; j++)
        if (beatCyc[j] == c - 1) begin
          expEnW  = '1;
          expWght = beatData[j];
        end
      expWReady = (c >= 2) && (beats < H);
      expIReady = (s >= 0) && (c >= s) && (c == boundary) && (nAcc < n);
      expEnI = '0; expClrI = '0; expDoneI = '0; expIfm = '0;
      for (int h = 0; h < H; h++) begin
        t = c - h;
        for (int k = 0; k < nAcc; k++) begin
          if ((t >= accCyc[k] + 1) && (t <= accCyc[k] + m)) begin
            expEnI[h] = 1'b1;
            expIfm[h] = vecData[k][h];
          end
          if (t == accCyc[k] + 1) expClrI[h] = 1'b1;
          if (t == accCyc[k] + m) expDoneI[h] = 1'b1;
        end
      end
      expEnO = '0; expClrO = '0; expDone = 1'b0;
      if (q >= 0) begin
        d = c - q;
        for (int w = 0; w < W; w++) begin
          expEnO[w]  = (d >= D0 + w) && (d <= D0 + w + H - 1);
          expClrO[w] = (d == D0 + w + H);
        end
        expDone = (d == DEND);
      end

      checkOutput("busy", 64'(busy), 64'(expBusy));
      checkOutput("clrW", 64'(clrW), 64'(expClrW));
      checkOutput("enW", 64'(enW), 64'(expEnW));
      if (expEnW != '0) checkOutput("wght", 64'(wghtOut), 64'(expWght));
      checkOutput("wReady", 64'(wghtReady), 64'(expWReady));
      checkOutput("iReady", 64'(ifmReady), 64'(expIReady));
      checkOutput("enI", 64'(enI), 64'(expEnI));
      checkOutput("clrI", 64'(clrI), 64'(expClrI));
      checkOutput("macDone", 64'(macDone), 64'(expDoneI));
      for (int h = 0; h < H; h++)
        if (expEnI[h]) checkOutput($sformatf("ifm%0d", h), 64'(ifmOut[h]), 64'(expIfm[h]));
      checkOutput("enO", 64'(enO), 64'(expEnO));
      checkOutput("clrO", 64'(clrO), 64'(expClrO));
      checkOutput("done", 64'(done), 64'(expDone));
`ifdef FEEDER_PERF_CNT_EN
      if (c >= 1) checkOutput("stallCnt", 64'(stallCnt), 64'(stalls));
`endif

      if ((rstOfs >= 0) && (s >= 0) && (c == s + rstOfs)) begin
        midReset();
        return;
      end

      st  = 1'b0;
      mac = CW'($urandom_range(0, 255));
      num = CW'($urandom_range(0, 255));
      if (c == 0) begin
        st  = 1'b1;
        mac = CW'(macIn);
        num = CW'(numIn);
      end else if (expBusy && ($urandom_range(0, 9) == 0)) begin
        st = 1'b1;
      end

      wv = ($urandom_range(0, 99) < 30);
      wd = rand64();
      if (beats < H) begin
        wd = beatData[beats];
        wv = (c >= 1) && ($urandom_range(0, 99) < wPct);
        if ((c >= 2) && wv) begin
          beatCyc[beats] = c;
          beats++;
          if (beats == H) begin
            s = c + 1;
            boundary = s;
          end
        end
      end

      iv = ($urandom_range(0, 99) < 30);
      id = rand64();
      if ((s >= 0) && (c >= s) && (c == boundary) && (nAcc < n)) begin
        if (fixedGap >= 0) iv = (nAcc == 0) || (gapRun >= fixedGap);
        else               iv = ($urandom_range(0, 99) < ifmPct);
        if (iv) begin
          id = vecData[nAcc];
          accCyc[nAcc] = c;
          nAcc++;
          boundary = c + m;
          gapRun = 0;
          if (nAcc == n) begin
            q = c + m + 1;
            doneCyc = q + DEND;
          end
        end else begin
          boundary = c + 1;
          stalls++;
          gapRun++;
        end
      end

      applyStimulus(st, mac, num, wv, wd, iv, id);
      @(negedge clk);
      c++;
      if ((q >= 0) && (c > doneCyc + 2)) begin
        finished = 1'b1;
      end else if (c >= 4000) begin
        checkOutput("tileTimeout", 64'd0, 64'd1);
        finished = 1'b1;
      end
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    #7 checkZeroOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    runTile(4, 1, 100, -1, 100, -1);
    runTile(3, 2, 100, -1, 100, -1);
    runTile(3, 2, 100, 2, 100, -1);
    runTile(0, 0, 100, -1, 100, -1);
    runTile(3, 4, 100, -1, 100, 4);
    runTile(1, 3, 100, 1, 70, -1);
    for (int i = 0; i < 20; i++)
      runTile($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(40, 100), -1,
              $urandom_range(40, 100), -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
